// File: rtl/bot_update_responder.sv
// HCLK-side responder for the Rojobot update handshake: waits for the update flag,
// double-samples the asynchronous bot info bus until it is stable, commits it, then acks.
//
// state  | meaning
// IDLE   | waiting for BOT_UPDATE_SYNC
// SETTLE | letting BOT_INFO settle before sampling
// SAMPA  | capture first sample
// SAMPB  | capture second sample
// CMP    | compare samples; commit, or retry after another settle
// ACK    | INT_ACK high, waiting for flag to drop
// HOLD   | ack timed out; wait for flag low without committing again
module bot_update_responder #(
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_RETRY     = 3,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        BOT_UPDATE_SYNC,
    input  logic [31:0] BOT_INFO,
    input  logic        SNAP_RD,
    input  logic        ERR_CLR,
    output logic        INT_ACK,
    output logic [31:0] SNAP_INFO,
    output logic        SNAP_VALID,
    output logic [15:0] UPD_COUNT,
    output logic        OVERRUN,
    output logic        ACK_TO_ERR,
    output logic        FORCED
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_SAMPA, S_SAMPB, S_CMP, S_ACK, S_HOLD
    } state_e;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);
    localparam logic [7:0] ACK_LAST    = 8'(ACK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [3:0]  settle_ctr_q, settle_ctr_d;
    logic [2:0]  retry_q, retry_d;
    logic [7:0]  ack_ctr_q, ack_ctr_d;
    logic [31:0] sa_q, sa_d;
    logic [31:0] sb_q, sb_d;
    logic [31:0] snap_q, snap_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;
    logic        overrun_q, overrun_d;
    logic        ack_to_q, ack_to_d;
    logic        forced_q, forced_d;
    logic        int_ack_q, int_ack_d;

    logic mismatch;
    logic retry_ok;
    logic commit;
    logic forced_now;

    assign mismatch   = (sa_q != sb_q);
    assign retry_ok   = (retry_q < RETRY_MAX);
    assign commit     = (state_q == S_CMP) && !(mismatch && retry_ok);
    assign forced_now = (state_q == S_CMP) && mismatch && !retry_ok;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (BOT_UPDATE_SYNC) state_d = S_SETTLE;
            S_SETTLE: if (settle_ctr_q == 4'd0) state_d = S_SAMPA;
            S_SAMPA:  state_d = S_SAMPB;
            S_SAMPB:  state_d = S_CMP;
            S_CMP:    state_d = (mismatch && retry_ok) ? S_SETTLE : S_ACK;
            S_ACK: begin
                if (!BOT_UPDATE_SYNC)          state_d = S_IDLE;
                else if (ack_ctr_q == ACK_LAST) state_d = S_HOLD;
            end
            S_HOLD:   if (!BOT_UPDATE_SYNC) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        settle_ctr_d = settle_ctr_q;
        retry_d      = retry_q;
        ack_ctr_d    = ack_ctr_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        snap_d       = snap_q;
        valid_d      = valid_q;
        count_d      = count_q;
        overrun_d    = overrun_q;
        ack_to_d     = ack_to_q;
        forced_d     = forced_q;
        int_ack_d    = (state_d == S_ACK);

        case (state_q)
            S_IDLE: if (BOT_UPDATE_SYNC) begin
                settle_ctr_d = SETTLE_LOAD;
                retry_d      = 3'd0;
            end
            S_SETTLE: if (settle_ctr_q != 4'd0) settle_ctr_d = settle_ctr_q - 4'd1;
            S_SAMPA:  sa_d = BOT_INFO;
            S_SAMPB:  sb_d = BOT_INFO;
            S_CMP: begin
                if (mismatch && retry_ok) begin
                    retry_d      = retry_q + 3'd1;
                    settle_ctr_d = SETTLE_LOAD;
                end else begin
                    ack_ctr_d = 8'd0;
                end
            end
            S_ACK: if (BOT_UPDATE_SYNC && ack_ctr_q != ACK_LAST) ack_ctr_d = ack_ctr_q + 8'd1;
            default: ;
        endcase

        // Clears are applied first so a same-cycle set or commit takes priority.
        if (SNAP_RD) valid_d = 1'b0;
        if (ERR_CLR) begin
            overrun_d = 1'b0;
            ack_to_d  = 1'b0;
            forced_d  = 1'b0;
        end
        if (commit) begin
            snap_d  = sb_q;
            valid_d = 1'b1;
            count_d = count_q + 16'd1;
            if (valid_q && !SNAP_RD) overrun_d = 1'b1;
        end
        if (forced_now) forced_d = 1'b1;
        if (state_q == S_ACK && state_d == S_HOLD) ack_to_d = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            settle_ctr_q <= 4'd0;
            retry_q      <= 3'd0;
            ack_ctr_q    <= 8'd0;
            sa_q         <= 32'd0;
            sb_q         <= 32'd0;
            snap_q       <= 32'd0;
            valid_q      <= 1'b0;
            count_q      <= 16'd0;
            overrun_q    <= 1'b0;
            ack_to_q     <= 1'b0;
            forced_q     <= 1'b0;
            int_ack_q    <= 1'b0;
        end else begin
            settle_ctr_q <= settle_ctr_d;
            retry_q      <= retry_d;
            ack_ctr_q    <= ack_ctr_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            snap_q       <= snap_d;
            valid_q      <= valid_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            ack_to_q     <= ack_to_d;
            forced_q     <= forced_d;
            int_ack_q    <= int_ack_d;
        end
    end

    assign INT_ACK    = int_ack_q;
    assign SNAP_INFO  = snap_q;
    assign SNAP_VALID = valid_q;
    assign UPD_COUNT  = count_q;
    assign OVERRUN    = overrun_q;
    assign ACK_TO_ERR = ack_to_q;
    assign FORCED     = forced_q;

endmodule

// File: tb/tb_bot_update_responder.sv
// Bench for bot_update_responder: directed and randomized update sequences checked
// against a transaction-level model of snapshot, counter and sticky flag behaviour.
module tb_bot_update_responder;

    localparam int SETTLE = 4;
    localparam int MAXR   = 3;
    localparam int ACKTO  = 64;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        BOT_UPDATE_SYNC = 1'b0;
    logic [31:0] BOT_INFO = 32'd0;
    logic        SNAP_RD = 1'b0;
    logic        ERR_CLR = 1'b0;
    logic        INT_ACK;
    logic [31:0] SNAP_INFO;
    logic        SNAP_VALID;
    logic [15:0] UPD_COUNT;
    logic        OVERRUN;
    logic        ACK_TO_ERR;
    logic        FORCED;

    bot_update_responder #(
        .SETTLE_CYCLES(SETTLE), .MAX_RETRY(MAXR), .ACK_TIMEOUT(ACKTO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .BOT_UPDATE_SYNC(BOT_UPDATE_SYNC),
        .BOT_INFO(BOT_INFO), .SNAP_RD(SNAP_RD), .ERR_CLR(ERR_CLR),
        .INT_ACK(INT_ACK), .SNAP_INFO(SNAP_INFO), .SNAP_VALID(SNAP_VALID),
        .UPD_COUNT(UPD_COUNT), .OVERRUN(OVERRUN), .ACK_TO_ERR(ACK_TO_ERR),
        .FORCED(FORCED)
    );

    always #5 HCLK = ~HCLK;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic [31:0] m_snap;
    logic        m_valid, m_over, m_acker, m_forced;
    logic [15:0] m_count;

    // stimulus pattern for BOT_INFO: 0 stable, 1 toggles forever, 2 toggles for first attempt only
    int          mode;
    logic [31:0] v0, v1;

    function automatic logic [31:0] info_at(input int c);
        case (mode)
            1:       return (c % 2 == 1) ? v1 : v0;
            2:       return (c < 7 && c % 2 == 1) ? v1 : v0;
            default: return v0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic model_reset();
        m_snap = 32'd0; m_valid = 1'b0; m_over = 1'b0;
        m_acker = 1'b0; m_forced = 1'b0; m_count = 16'd0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".snap"},    SNAP_INFO,        m_snap);
        check({tag, ".valid"},   32'(SNAP_VALID),  32'(m_valid));
        check({tag, ".count"},   32'(UPD_COUNT),   32'(m_count));
        check({tag, ".overrun"}, 32'(OVERRUN),     32'(m_over));
        check({tag, ".ack_to"},  32'(ACK_TO_ERR),  32'(m_acker));
        check({tag, ".forced"},  32'(FORCED),      32'(m_forced));
    endtask

    // One flag assertion. The model derives retries, latency and committed word from the
    // sampling schedule: attempt r samples at cycles 5+7r and 6+7r, commit visible at 8+7r.
    task automatic run_update(input string tag, input int md, input logic [31:0] a,
                              input logic [31:0] b, input bit rd_commit,
                              input bit clr_commit, input int hold);
        int r, vis;
        bit fz;
        logic [31:0] exp_snap;
        mode = md; v0 = a; v1 = b;
        r = 0;
        while (r < MAXR && info_at(5 + 7*r) != info_at(6 + 7*r)) r++;
        fz       = (info_at(5 + 7*r) != info_at(6 + 7*r));
        vis      = 8 + 7*r;
        exp_snap = info_at(6 + 7*r);

        BOT_UPDATE_SYNC = 1'b1;
        BOT_INFO = info_at(0);
        for (int c = 1; c <= vis; c++) begin
            tick();
            BOT_INFO = info_at(c);
            SNAP_RD  = rd_commit  && (c == vis - 1);
            ERR_CLR  = clr_commit && (c == vis - 1);
            if (c == vis - 1) check({tag, ".ack_before_commit"}, 32'(INT_ACK), 32'd0);
        end
        SNAP_RD = 1'b0;
        ERR_CLR = 1'b0;
        if (clr_commit) begin
            m_over = 1'b0; m_acker = 1'b0; m_forced = 1'b0;
        end
        if (m_valid && !rd_commit) m_over = 1'b1;
        m_valid = 1'b1;
        m_count = m_count + 16'd1;
        m_snap  = exp_snap;
        if (fz) m_forced = 1'b1;
        check({tag, ".ack_at_commit"}, 32'(INT_ACK), 32'd1);
        check_all({tag, ".commit"});

        for (int k = 1; k <= hold + 1; k++) begin
            tick();
            if (k == hold) BOT_UPDATE_SYNC = 1'b0;
            BOT_INFO = $urandom;
            check({tag, ".ack_hold"}, 32'(INT_ACK), 32'(k <= hold && k < ACKTO));
            if (k == ACKTO - 1) check({tag, ".ack_to_early"}, 32'(ACK_TO_ERR), 32'(m_acker));
        end
        if (hold >= ACKTO) m_acker = 1'b1;
        check_all({tag, ".after"});
    endtask

    task automatic gap(input string tag, input bit rd, input bit clr);
        tick();
        SNAP_RD = rd;
        ERR_CLR = clr;
        tick();
        SNAP_RD = 1'b0;
        ERR_CLR = 1'b0;
        if (rd) m_valid = 1'b0;
        if (clr) begin
            m_over = 1'b0; m_acker = 1'b0; m_forced = 1'b0;
        end
        check_all(tag);
        check({tag, ".idle_ack"}, 32'(INT_ACK), 32'd0);
    endtask

    initial begin
        logic [31:0] x;
        model_reset();

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            BOT_UPDATE_SYNC = 1'($urandom);
            BOT_INFO = $urandom;
            SNAP_RD  = 1'($urandom);
            ERR_CLR  = 1'($urandom);
            tick();
        end
        check("rst.ack", 32'(INT_ACK), 32'd0);
        check_all("rst");
        BOT_UPDATE_SYNC = 1'b0; SNAP_RD = 1'b0; ERR_CLR = 1'b0;
        HRESETn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("rst_idle.ack", 32'(INT_ACK), 32'd0);
        check_all("rst_idle");

        // basic update
        run_update("basic", 0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1);

        // instability: forced commit, then stable on second attempt
        gap("inst_pre", 1'b1, 1'b1);
        x = $urandom;
        run_update("inst_forced", 1, x, ~x, 1'b1, 1'b0, 2);
        gap("inst_clr", 1'b0, 1'b1);
        x = $urandom;
        run_update("inst_retry1", 2, x, x ^ 32'h0000_0100, 1'b1, 1'b0, 3);

        // overrun and read race
        gap("ovr_pre", 1'b1, 1'b1);
        run_update("ovr_a", 0, $urandom, 32'h0, 1'b0, 1'b0, 1);
        run_update("ovr_b", 0, $urandom, 32'h0, 1'b0, 1'b0, 1);
        gap("ovr_clr", 1'b0, 1'b1);
        run_update("race_rd", 0, $urandom, 32'h0, 1'b1, 1'b0, 2);
        run_update("ovr_c", 0, $urandom, 32'h0, 1'b0, 1'b0, 1);
        run_update("set_wins", 0, $urandom, 32'h0, 1'b0, 1'b1, 1);
        gap("ovr_clr2", 1'b1, 1'b1);

        // ack timeout then normal recovery
        run_update("ackto", 0, $urandom, 32'h0, 1'b0, 1'b0, ACKTO + 20);
        gap("ackto_gap", 1'b1, 1'b0);
        run_update("ackto_recover", 0, $urandom, 32'h0, 1'b1, 1'b0, 2);
        gap("ackto_clr", 1'b0, 1'b1);

        // randomized updates
        for (int i = 0; i < 12; i++) begin
            x = $urandom;
            run_update("rand", int'($urandom_range(0, 2)), x, ~x,
                       1'($urandom), 1'($urandom), int'($urandom_range(1, 6)));
            gap("rand_gap", 1'($urandom), 1'($urandom));
        end

        // counter wrap via preload of the count register
        force dut.count_q = 16'hFFFF;
        tick();
        release dut.count_q;
        m_count = 16'hFFFF;
        tick();
        check("wrap_pre.count", 32'(UPD_COUNT), 32'h0000_FFFF);
        run_update("wrap", 0, $urandom, 32'h0, 1'b1, 1'b0, 1);
        run_update("post_wrap", 0, $urandom, 32'h0, 1'b0, 1'b0, 1);

        // reset in the middle of SETTLE aborts without commit
        BOT_UPDATE_SYNC = 1'b1;
        BOT_INFO = $urandom;
        tick();
        tick();
        HRESETn = 1'b0;
        #1;
        model_reset();
        check("midrst.ack", 32'(INT_ACK), 32'd0);
        check_all("midrst");
        BOT_UPDATE_SYNC = 1'b0;
        tick();
        HRESETn = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("midrst_after.ack", 32'(INT_ACK), 32'd0);
        check_all("midrst_after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
